reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Central reset sequencer: holds all domains in reset, waits for PLL lock, then releases domains
// one at a time in ascending order. Define RST_SEQ_WDOG_EN to add the watchdog reset source.
module reset_sequencer #(
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT   = 1024,
`ifdef RST_SEQ_WDOG_EN
    parameter int unsigned WDOG_CYCLES    = 4096,
`endif
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   ext_rst_req,
    input  logic                   sw_rst_req,
    input  logic                   pll_locked,
`ifdef RST_SEQ_WDOG_EN
    input  logic                   wdog_kick,
`endif
    output logic [NUM_DOMAINS-1:0] rstn_out,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic [3:0]             rst_cause,
    output logic                   lock_err
);

    localparam int unsigned IDX_W = $clog2(NUM_DOMAINS + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_DOMAINS);

    typedef enum logic [1:0] {StAssert, StWaitLock, StRelease, StRun} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   ext_meta_q, ext_sync_q;
    logic [NUM_DOMAINS-1:0] rstn_q, rstn_d;
    logic                   seq_busy_q, seq_busy_d;
    logic                   seq_done_q, seq_done_d;
    logic [3:0]             rst_cause_q, rst_cause_d;
    logic                   lock_err_q, lock_err_d;
    logic                   wdog_req;
    logic                   rst_req;

`ifdef RST_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] wdog_q, wdog_d;

    // A kick on the terminal count suppresses the request.
    assign wdog_req = (state_q == StRun) && !wdog_kick && (wdog_q == WDOG_LAST);

    always_comb begin
        wdog_d = '0;
        if (state_q == StRun && state_d == StRun && !wdog_kick) begin
            wdog_d = wdog_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_req = 1'b0;
`endif

    assign rst_req = ext_sync_q | sw_rst_req | wdog_req;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q     <= StAssert;
            cnt_q       <= '0;
            idx_q       <= '0;
            ext_meta_q  <= 1'b0;
            ext_sync_q  <= 1'b0;
            rstn_q      <= '0;
            seq_busy_q  <= 1'b1;
            seq_done_q  <= 1'b0;
            rst_cause_q <= 4'b0001;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ext_meta_q  <= ext_rst_req;
            ext_sync_q  <= ext_meta_q;
            rstn_q      <= rstn_d;
            seq_busy_q  <= seq_busy_d;
            seq_done_q  <= seq_done_d;
            rst_cause_q <= rst_cause_d;
            lock_err_q  <= lock_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        if (rst_req) begin
            state_d = StAssert;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StAssert: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    if (pll_locked || cnt_q == LOCK_LAST) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                        idx_d   = IDX_W'(1);
                    end
                end
                StRelease: begin
                    if (idx_q == IDX_END) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else if (cnt_q == STAG_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = '0;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rstn_d      = rstn_q;
        rst_cause_d = rst_cause_q;
        lock_err_d  = lock_err_q;
        if (rst_req) begin
            rstn_d      = '0;
            rst_cause_d = {wdog_req, sw_rst_req, ext_sync_q, 1'b0};
        end else begin
            if (state_q == StWaitLock && state_d == StRelease) begin
                rstn_d[0] = 1'b1;
                if (!pll_locked) begin
                    lock_err_d = 1'b1;
                end
            end
            if (state_q == StRelease && cnt_q == STAG_LAST) begin
                for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        rstn_d[k] = 1'b1;
                    end
                end
            end
            if (state_d == StRun) begin
                rstn_d = '1;
            end
        end
        seq_busy_d = (state_d != StRun);
        seq_done_d = (state_d == StRun) && (state_q != StRun);
    end

    assign rstn_out  = rstn_q;
    assign seq_busy  = seq_busy_q;
    assign seq_done  = seq_done_q;
    assign rst_cause = rst_cause_q;
    assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer; the reference model tracks elapsed edges since the
// last restart and derives every release time arithmetically.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 16;
    localparam int S    = 4;
    localparam int LT   = 8;
    localparam int WD   = 32;
    localparam int OW   = N + 7;

    logic         clk = 1'b0;
    logic         sync_rst = 1'b1;
    logic         ext_rst_req = 1'b0;
    logic         sw_rst_req = 1'b0;
    logic         pll_locked = 1'b0;
    logic         wdog_kick = 1'b0;
    logic [N-1:0] rstn_out;
    logic         seq_busy;
    logic         seq_done;
    logic [3:0]   rst_cause;
    logic         lock_err;
    logic [OW-1:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_t = edges since last restart, m_e = edge (in m_t terms) that began releasing.
    int         m_t = 0;
    int         m_e = -1;
    int         m_wclr = 0;
    logic [3:0] m_cause = 4'b0001;
    logic       m_lock_err = 1'b0;
    logic       m_h0 = 1'b0;
    logic       m_h1 = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS   (N),
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(S),
        .LOCK_TIMEOUT  (LT),
`ifdef RST_SEQ_WDOG_EN
        .WDOG_CYCLES   (WD),
`endif
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .ext_rst_req(ext_rst_req),
        .sw_rst_req (sw_rst_req),
        .pll_locked (pll_locked),
`ifdef RST_SEQ_WDOG_EN
        .wdog_kick  (wdog_kick),
`endif
        .rstn_out   (rstn_out),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .rst_cause  (rst_cause),
        .lock_err   (lock_err)
    );

    assign obs = {rstn_out, seq_busy, seq_done, rst_cause, lock_err};

    function automatic logic [OW-1:0] model_out();
        logic [N-1:0] r;
        logic         run;
        int           done_t;
        done_t = m_e + (N - 1) * S + 1;
        for (int k = 0; k < N; k++) begin
            r[k] = (m_e >= 0) && (m_t >= m_e + k * S);
        end
        run = (m_e >= 0) && (m_t >= done_t);
        return {r, !run, (m_e >= 0) && (m_t == done_t), m_cause, m_lock_err};
    endfunction

    // Advances one edge, updates the model from the inputs sampled at that edge.
    task automatic step();
        logic r_ext, r_sw, r_wd, was_run;
        int   done_t;
        @(posedge clk);
        if (sync_rst) begin
            m_t = 0; m_e = -1; m_wclr = 0;
            m_cause = 4'b0001; m_lock_err = 1'b0;
            m_h0 = 1'b0; m_h1 = 1'b0;
        end else begin
            done_t  = m_e + (N - 1) * S + 1;
            was_run = (m_e >= 0) && (m_t >= done_t);
            r_ext = m_h1;
            m_h1  = m_h0;
            m_h0  = ext_rst_req;
            r_sw  = sw_rst_req;
            r_wd  = 1'b0;
`ifdef RST_SEQ_WDOG_EN
            r_wd = was_run && !wdog_kick && (m_t + 1 - m_wclr == WD);
`endif
            if (r_ext || r_sw || r_wd) begin
                m_t = 0;
                m_e = -1;
                m_cause = {r_wd, r_sw, r_ext, 1'b0};
            end else begin
                m_t++;
                if (m_e < 0 && m_t > HOLD && (pll_locked || m_t == HOLD + LT)) begin
                    m_e = m_t;
                    if (!pll_locked) m_lock_err = 1'b1;
                end
                done_t = m_e + (N - 1) * S + 1;
                if (m_e >= 0 && m_t == done_t) m_wclr = m_t;
                else if (wdog_kick) m_wclr = m_t;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (obs !== {{N{1'b0}}, 1'b1, 1'b0, 4'b0001, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values: got %b exp %b", obs, {{N{1'b0}}, 7'b1000010});
            end
        end
        sync_rst = 1'b0;
    endtask

    task automatic test_por();
        pll_locked = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL por_e%0d: got %b exp %b", i, obs, model_out());
            end
            if ((i == 16 && rstn_out !== 3'b000) || (i == 17 && rstn_out !== 3'b001) ||
                (i == 20 && rstn_out !== 3'b001) || (i == 21 && rstn_out !== 3'b011) ||
                (i == 25 && rstn_out !== 3'b111)) begin
                n_fail++;
                $display("FAIL por_release_e%0d: rstn_out %b", i, rstn_out);
            end
            if (i == 26 || i == 27) begin
                n_checks++;
                if (seq_done !== (i == 26) || seq_busy !== 1'b0 || rst_cause !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL por_done_e%0d: done %b busy %b cause %b", i, seq_done,
                             seq_busy, rst_cause);
                end
            end
        end
    endtask

    task automatic test_lock_timeout();
        sync_rst = 1'b1;
        pll_locked = 1'b0;
        step();
        sync_rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL lock_e%0d: got %b exp %b", i, obs, model_out());
            end
            if ((i == 23 && (lock_err !== 1'b0 || rstn_out !== 3'b000)) ||
                (i == 24 && (lock_err !== 1'b1 || rstn_out !== 3'b001))) begin
                n_fail++;
                $display("FAIL lock_timeout_e%0d: lock_err %b rstn_out %b", i, lock_err, rstn_out);
            end
        end
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        n_checks++;
        if (lock_err !== 1'b1 || rstn_out !== 3'b000 || rst_cause !== 4'b0100) begin
            n_fail++;
            $display("FAIL lock_sticky: lock_err %b rstn_out %b cause %b", lock_err, rstn_out,
                     rst_cause);
        end
        pll_locked = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL lock_resume_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
    endtask

    task automatic test_sw_from_run();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        n_checks++;
        if (rstn_out !== 3'b000 || rst_cause !== 4'b0100 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_entry: rstn_out %b cause %b busy %b", rstn_out, rst_cause, seq_busy);
        end
        for (int i = 1; i <= 30; i++) begin
            step();
            n_checks++;
            if (obs !== model_out() || (i == 26 && seq_done !== 1'b1)) begin
                n_fail++;
                $display("FAIL sw_seq_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
    endtask

    task automatic test_abort();
        logic found;
        found = 1'b0;
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL abort_pre_e%0d: got %b exp %b", i, obs, model_out());
            end
            found = (rstn_out === 3'b001);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_wait: rstn_out %b never reached 001", rstn_out);
        end
        ext_rst_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (obs !== model_out() || (i < 3 && rstn_out !== 3'b001) ||
                (i == 3 && (rstn_out !== 3'b000 || rst_cause !== 4'b0010))) begin
                n_fail++;
                $display("FAIL abort_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
        ext_rst_req = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL abort_restart_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            ext_rst_req = (i == 0);
            sw_rst_req  = (i == 2);
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL simul_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
        ext_rst_req = 1'b0;
        sw_rst_req  = 1'b0;
        n_checks++;
        if (rst_cause !== 4'b0110 || rstn_out !== 3'b000) begin
            n_fail++;
            $display("FAIL simul_cause: cause %b rstn_out %b exp 0110/000", rst_cause, rstn_out);
        end
    endtask

    task automatic test_sync_mid();
        for (int i = 1; i <= 20; i++) begin
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL sync_pre_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        n_checks++;
        if (obs !== {{N{1'b0}}, 1'b1, 1'b0, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL sync_mid: got %b exp %b", obs, {{N{1'b0}}, 7'b1000010});
        end
    endtask

`ifdef RST_SEQ_WDOG_EN
    task automatic test_wdog();
        pll_locked = 1'b1;
        for (int i = 1; i <= 58; i++) begin
            step();
            n_checks++;
            if (obs !== model_out() || (i == 57 && rstn_out !== 3'b111) ||
                (i == 58 && (rstn_out !== 3'b000 || rst_cause !== 4'b1000))) begin
                n_fail++;
                $display("FAIL wdog_timeout_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
        for (int i = 1; i <= 90; i++) begin
            wdog_kick = (i == 58);
            step();
            wdog_kick = 1'b0;
            n_checks++;
            if (obs !== model_out() || (i == 58 && rstn_out !== 3'b111) ||
                (i == 89 && rstn_out !== 3'b111) ||
                (i == 90 && (rstn_out !== 3'b000 || rst_cause !== 4'b1000))) begin
                n_fail++;
                $display("FAIL wdog_kick_e%0d: got %b exp %b", i, obs, model_out());
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            sync_rst   = ($urandom_range(0, 399) == 0);
            sw_rst_req = ($urandom_range(0, 199) == 0);
            if (ext_rst_req) ext_rst_req = ($urandom_range(0, 2) != 0);
            else ext_rst_req = ($urandom_range(0, 299) == 0);
            pll_locked = ($urandom_range(0, 7) == 0);
            wdog_kick  = ($urandom_range(0, 39) == 0);
            step();
            n_checks++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b exp %b", i, obs, model_out());
            end
        end
        sync_rst = 1'b0;
        sw_rst_req = 1'b0;
        ext_rst_req = 1'b0;
        wdog_kick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_por();
        test_lock_timeout();
        test_sw_from_run();
        test_abort();
        test_simultaneous();
        test_sync_mid();
`ifdef RST_SEQ_WDOG_EN
        test_wdog();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
